// File: rtl/fixed_div_module.sv
// Signed fixed-point divider: out = num / den in Q(32-Q_BITS).Q_BITS.
// Restoring division on magnitudes, one quotient bit per cycle, followed by
// sign fix-up with saturation and a single write into the output FIFO.
module fixed_div_module #(
    parameter int unsigned Q_BITS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] num,
    input  logic        num_empty,
    input  logic [31:0] den,
    input  logic        den_empty,
    output logic        in_rd_en,
    output logic [31:0] out,
    output logic        out_dbz,
    input  logic        out_full,
    output logic        out_wr_en
);

    localparam int unsigned ITER  = 32 + Q_BITS;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {StIdle, StDiv, StFix, StWrite} state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic              r_sign;
    logic              r_nsign;
    logic              r_den_zero;
    logic [32:0]       r_den_abs;
    logic [ITER-1:0]   r_dividend;
    logic [ITER-1:0]   r_quot;
    logic [32:0]       r_rem;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic [31:0]       w_num_abs;
    logic [31:0]       w_den_abs;
    logic [33:0]       w_rem_shift;
    logic              w_ge;
    logic [31:0]       w_fix_out;
    logic              w_fix_dbz;

    // Magnitudes as unsigned 32-bit values; -2^31 maps to 0x80000000 exactly.
    assign w_num_abs   = num[31] ? (~num + 32'd1) : num;
    assign w_den_abs   = den[31] ? (~den + 32'd1) : den;

    assign w_rem_shift = {r_rem, r_dividend[ITER-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_den_abs});

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_pop) w_state_next = (den == 32'd0) ? StFix : StDiv;
            StDiv:   if (r_count == CNT_W'(ITER - 1)) w_state_next = StFix;
            StFix:   w_state_next = StWrite;
            StWrite: if (!out_full) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Handshake outputs; pop is held off while reset is asserted
    always_comb begin
        w_pop     = reset_n && (r_state == StIdle) && !num_empty && !den_empty;
        in_rd_en  = w_pop;
        out_wr_en = (r_state == StWrite) && !out_full;
    end

    // Sign fix-up with saturation to the signed 32-bit range
    always_comb begin
        w_fix_out = '0;
        w_fix_dbz = 1'b0;
        if (r_den_zero) begin
            w_fix_dbz = 1'b1;
            w_fix_out = r_nsign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (!r_sign) begin
            w_fix_out = (r_quot > ITER'(32'h7FFF_FFFF)) ? 32'h7FFF_FFFF : r_quot[31:0];
        end else begin
            w_fix_out = (r_quot > ITER'(32'h8000_0000)) ? 32'h8000_0000
                                                         : (~r_quot[31:0] + 32'd1);
        end
    end

    // Datapath: operand capture, restoring steps, result register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sign     <= 1'b0;
            r_nsign    <= 1'b0;
            r_den_zero <= 1'b0;
            r_den_abs  <= '0;
            r_dividend <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            out        <= '0;
            out_dbz    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_sign     <= num[31] ^ den[31];
                        r_nsign    <= num[31];
                        r_den_zero <= (den == 32'd0);
                        r_den_abs  <= {1'b0, w_den_abs};
                        r_dividend <= {w_num_abs, {Q_BITS{1'b0}}};
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_count    <= '0;
                    end
                end
                StDiv: begin
                    r_rem      <= w_ge ? 33'(w_rem_shift - {1'b0, r_den_abs})
                                       : 33'(w_rem_shift);
                    r_quot     <= {r_quot[ITER-2:0], w_ge};
                    r_dividend <= r_dividend << 1;
                    r_count    <= r_count + CNT_W'(1);
                end
                StFix: begin
                    out     <= w_fix_out;
                    out_dbz <= w_fix_dbz;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fixed_div_module.md
Name: fixed_div_module

Overview:
Signed fixed-point divider that sits directly downstream of two dot-product stages. It consumes a numerator/denominator pair, e.g. the two dot products of a ray-plane intersection t = dot(n, p0-o) / dot(n, d). It computes num/den in Q(32-Q_BITS).Q_BITS using iterative restoring division at one quotient bit per cycle, then writes one result word into the output FIFO through the standard empty/rd_en and full/wr_en handshakes.

Parameters:
Q_BITS, 16, fractional bits of inputs and output; dividend width is 32+Q_BITS.
ITER, 32+Q_BITS (derived, localparam), number of division iterations.

Ports:
clock  input  1  single clock; all state on posedge.
reset_n  input  1  asynchronous, active-low reset.
num  input  32 signed  numerator; FIFO show-ahead dout, valid while !num_empty.
num_empty  input  1  numerator FIFO empty.
den  input  32 signed  denominator; FIFO show-ahead dout, valid while !den_empty.
den_empty  input  1  denominator FIFO empty.
in_rd_en  output  1  pops both input FIFOs together.
out  output  32 signed  quotient, Q format; drives output FIFO din.
out_dbz  output  1  divide-by-zero flag accompanying out.
out_full  input  1  output FIFO full.
out_wr_en  output  1  output FIFO write strobe.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; out=0, out_dbz=0; counter, remainder and quotient registers cleared. in_rd_en and out_wr_en are combinational from state, so both are 0 during reset.
- A reset asserted in any state abandons the operation. No write occurs and no further pop occurs.
- IDLE: in_rd_en=1 iff !num_empty && !den_empty. On that cycle, latch:
  - sign = num[31]^den[31];
  - nsign = num[31];
  - |num| and |den| as 33-bit unsigned, so -2^31 is handled;
  - dividend = |num| << Q_BITS;
  - count = 0.
  Next state: FIX if den==0, else DIV.
- DIV: one restoring step per cycle, MSB first: rem = (rem<<1)|next dividend bit; if rem >= |den| then rem -= |den| and the quotient bit is 1, else 0. count increments each cycle. After ITER cycles the state goes to FIX.
- FIX (1 cycle), registers out and out_dbz:
  - den==0: out=0x7FFFFFFF if nsign=0, else 0x80000000; out_dbz=1.
  - Positive result (sign=0): quotient magnitude q > 0x7FFFFFFF gives 0x7FFFFFFF; otherwise out=q.
  - Negative result (sign=1): q > 0x80000000 gives 0x80000000; otherwise out=-q.
  - out_dbz=0 in both non-zero-denominator cases.
  - Rounding is truncation toward zero.
  - Next state: WRITE.
- WRITE: out_wr_en=1 iff !out_full. When written, the next state is IDLE; otherwise stay in WRITE. out and out_dbz are stable in WRITE and hold their value until the next FIX.
- No pop while busy: in_rd_en=0 in DIV, FIX and WRITE. Only one operation is in flight at a time.
- Latency, counted from the pop cycle P (in_rd_en=1), with out_full=0:
  - normal operation: DIV occupies P+1..P+ITER, FIX is P+ITER+1, out_wr_en is at P+ITER+2 (P+50 for Q_BITS=16);
  - den==0: FIX at P+1, out_wr_en at P+2.
- Earliest next pop is the cycle after the write, giving a throughput of 1 result per ITER+3 cycles.
- Empty inputs: if only one input FIFO is non-empty, stay in IDLE with no pop.
- Simultaneous events: out_full deasserting during the WRITE cycle is sampled combinationally, and the write happens that cycle.

Test Plan:
- num=0x00030000 (3.0), den=0x00020000 (2.0) -> out=0x00018000, out_dbz=0; out_wr_en exactly 50 cycles after the in_rd_en cycle; exactly one write.
- num=0xFFFF0000 (-1.0), den=0x00030000 (3.0) -> out=0xFFFFAAAB (truncation toward zero); also num=0x80000000, den=0xFFFF0000 -> saturates to 0x7FFFFFFF.
- Divide by zero:
  - den=0, num=0x00010000 -> out=0x7FFFFFFF, out_dbz=1, write 2 cycles after the pop;
  - den=0, num=0xFFFF0000 -> out=0x80000000, out_dbz=1.
- Overflow: num=0x7FFF0000, den=0x00000100 -> out=0x7FFFFFFF, out_dbz=0.
- Backpressure and empty inputs:
  - out_full held 1 for 10 cycles in WRITE -> out_wr_en=0 and out stable throughout, in_rd_en=0; on release, a single write, then a pop on the next cycle if inputs are available;
  - num_empty=0 with den_empty=1 -> no pop.
- Reset mid-DIV: drop reset_n low at pop+20 -> out=0, out_dbz=0, state IDLE immediately; no out_wr_en afterwards. A following pair 0x00010000/0x00010000 -> out=0x00010000.
